// File: rtl/lenet_sched_if.sv
// Signal bundle between the LeNet run scheduler and its environment:
// run control, frame-ready input, LeNet handshake and published status.
interface lenet_sched_if #(
  parameter int CNT_W = 16
);
  logic             enable;
  logic             data_ready;
  logic             lenet_ready;
  logic [3:0]       lenet_digit;
  logic             lenet_go;
  logic             busy;
  logic [3:0]       result_digit;
  logic             result_valid;
  logic             overrun;
  logic             timeout_err;
  logic [CNT_W-1:0] run_count;

  // Environment side: drives run control, frames and LeNet status.
  modport master (
    output enable, data_ready, lenet_ready, lenet_digit,
    input  lenet_go, busy, result_digit, result_valid, overrun, timeout_err, run_count
  );

  // Scheduler side.
  modport slave (
    input  enable, data_ready, lenet_ready, lenet_digit,
    output lenet_go, busy, result_digit, result_valid, overrun, timeout_err, run_count
  );
endinterface

// File: rtl/lenet_sched.sv
// LeNet inference scheduler: waits for a synchronized frame edge, pulses
// lenet_go, follows the lenet_ready handshake under a watchdog, and publishes
// a digit only once VOTE_DEPTH consecutive runs agree.
module lenet_sched #(
  parameter int TIMEOUT_CYCLES = 2000000,
  parameter int VOTE_DEPTH     = 3,
  parameter int CNT_W          = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  lenet_sched_if.slave bus
);
  localparam int WD_W   = $clog2(TIMEOUT_CYCLES);
  localparam int FILL_W = 4;
  localparam int HIST_W = 4 * VOTE_DEPTH;

  typedef enum logic [2:0] {
    S_IDLE, S_GO, S_WAIT_ACK, S_WAIT_DONE, S_LATCH, S_DRAIN
  } state_e;

  state_e             state_q, state_d;
  logic               sync1_q, sync2_q, sync3_q;
  logic               edge_s;
  logic               pending_q, pending_d;
  logic               overrun_q, overrun_d;
  logic               timeout_q, timeout_d;
  logic [WD_W-1:0]    wd_q, wd_d;
  logic [HIST_W-1:0]  hist_q, hist_d;   // newest digit in the low nibble
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic [3:0]         result_q, result_d;
  logic               valid_q, valid_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               go_q, go_d;
  logic               busy_q, busy_d;
  logic               expire_s;
  logic               abort_s;

  // Edges from the slower frame domain only count while runs are enabled.
  assign edge_s   = sync2_q & ~sync3_q & bus.enable;
  assign expire_s = (wd_q == WD_W'(TIMEOUT_CYCLES - 1));

  // Two-flop synchronizer for data_ready plus a history flop for edge detect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
    end else begin
      sync1_q <= bus.data_ready;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  // Next-state, frame bookkeeping, watchdog and vote logic.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    overrun_d = overrun_q;
    timeout_d = timeout_q;
    wd_d      = wd_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    result_d  = result_q;
    valid_d   = valid_q;
    count_d   = count_q;
    abort_s   = 1'b0;

    // The GO cycle consumes the pending frame; a coincident edge becomes the next one.
    if (state_q == S_GO) begin
      pending_d = edge_s;
    end else if (edge_s) begin
      pending_d = 1'b1;
      overrun_d = overrun_q | pending_q;
    end else begin
      pending_d = pending_q;
    end

    case (state_q)
      S_IDLE: begin
        if (!bus.enable) begin
          pending_d = 1'b0;
          overrun_d = 1'b0;
          timeout_d = 1'b0;
          valid_d   = 1'b0;
          hist_d    = '0;
          fill_d    = '0;
        end else if (pending_q && bus.lenet_ready) begin
          state_d = S_GO;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_GO: begin
        wd_d    = '0;
        state_d = bus.enable ? S_WAIT_ACK : S_DRAIN;
      end
      S_WAIT_ACK: begin
        wd_d = wd_q + WD_W'(1);
        if (!bus.enable) begin
          state_d = S_DRAIN;
        end else if (!bus.lenet_ready) begin
          state_d = S_WAIT_DONE;   // ack beats a simultaneous expiry
        end else if (expire_s) begin
          abort_s = 1'b1;
        end else begin
          state_d = S_WAIT_ACK;
        end
      end
      S_WAIT_DONE: begin
        wd_d = wd_q + WD_W'(1);
        if (!bus.enable) begin
          state_d = S_DRAIN;
        end else if (bus.lenet_ready) begin
          state_d = S_LATCH;
        end else if (expire_s) begin
          abort_s = 1'b1;
        end else begin
          state_d = S_WAIT_DONE;
        end
      end
      S_DRAIN: begin
        wd_d = wd_q + WD_W'(1);
        if (bus.lenet_ready) begin
          state_d = S_IDLE;        // result of the abandoned run is dropped
        end else if (expire_s) begin
          abort_s = 1'b1;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_LATCH: begin
        hist_d  = HIST_W'({hist_q, bus.lenet_digit});
        fill_d  = (fill_q < FILL_W'(VOTE_DEPTH)) ? fill_q + FILL_W'(1) : fill_q;
        count_d = count_q + CNT_W'(1);
        if ((fill_d == FILL_W'(VOTE_DEPTH)) && (hist_d == {VOTE_DEPTH{bus.lenet_digit}})) begin
          result_d = bus.lenet_digit;
          valid_d  = 1'b1;
        end else begin
          result_d = result_q;
        end
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Watchdog expiry: flag it and forget all vote history.
    if (abort_s) begin
      timeout_d = 1'b1;
      hist_d    = '0;
      fill_d    = '0;
      valid_d   = 1'b0;
      state_d   = S_IDLE;
    end else begin
      timeout_d = timeout_d;
    end

    go_d   = (state_d == S_GO);
    busy_d = (state_d == S_GO) || (state_d == S_WAIT_ACK) ||
             (state_d == S_WAIT_DONE) || (state_d == S_DRAIN);
  end

  // State, bookkeeping and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
      wd_q      <= '0;
      hist_q    <= '0;
      fill_q    <= '0;
      result_q  <= 4'd0;
      valid_q   <= 1'b0;
      count_q   <= '0;
      go_q      <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      timeout_q <= timeout_d;
      wd_q      <= wd_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      result_q  <= result_d;
      valid_q   <= valid_d;
      count_q   <= count_d;
      go_q      <= go_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.lenet_go     = go_q;
  assign bus.busy         = busy_q;
  assign bus.result_digit = result_q;
  assign bus.result_valid = valid_q;
  assign bus.overrun      = overrun_q;
  assign bus.timeout_err  = timeout_q;
  assign bus.run_count    = count_q;
endmodule
